// File: rtl/packet_sink_if.sv
// Flit link using the two-sided ready handshake: the master drives data and
// wr_ready (data valid); the slave answers with r_ready (can accept).
interface packet_sink_if #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         wr_ready;
    logic         r_ready;

    modport master (output data, output wr_ready, input  r_ready);
    modport slave  (input  data, input  wr_ready, output r_ready);
endinterface

// File: rtl/packet_sink.sv
// Receive endpoint: checks each packet's header address and length, queues good
// payload in a show-ahead FIFO, and keeps packet/error counters and an idle watchdog.
module packet_sink #(
    parameter int DATA_SIZE    = 8,
    parameter int ADDR_SIZE    = 4,
    parameter int ADDR         = 0,
    parameter int MAX_PACK_LEN = 4,
    parameter int MEM_LOG2     = 2,
    parameter int IDLE_LIMIT   = 10000
) (
    input  logic                 clk,
    input  logic                 a_rst,
    packet_sink_if.slave         flit_in,
    packet_sink_if.master        fifo_out,
    output logic [31:0]          recv_packs,
    output logic [15:0]          addr_errs,
    output logic [15:0]          len_errs,
    output logic                 timeout
);
    localparam int DEPTH = 1 << MEM_LOG2;
    localparam int PW    = MEM_LOG2 + 1;
    localparam int FW    = DATA_SIZE + 1;
    localparam int CNT_W = $clog2(MAX_PACK_LEN + 1);
    localparam logic [CNT_W:0]        MAX_LEN_C = (CNT_W + 1)'(MAX_PACK_LEN);
    localparam logic [ADDR_SIZE-1:0]  MY_ADDR   = ADDR_SIZE'(ADDR);
    localparam logic [31:0]           IDLE_MAX  = 32'(IDLE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   flit_cnt_q, flit_cnt_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]        recv_q, recv_d;
    logic [15:0]        addr_err_q, addr_err_d, len_err_q, len_err_d;
    logic [31:0]        idle_q, idle_d;
    logic               en_q;

    logic [FW-1:0]      mem [DEPTH];

    logic                 flit_last;
    logic [ADDR_SIZE-1:0] flit_dst;
    logic [DATA_SIZE-1:0] flit_data;
    logic                 full, empty, accept, pop;
    logic                 push, push_last, recv_inc, addr_inc, len_inc;
    logic [CNT_W:0]       cnt_next;

    assign flit_last = flit_in.data[DATA_SIZE+ADDR_SIZE];
    assign flit_dst  = flit_in.data[DATA_SIZE +: ADDR_SIZE];
    assign flit_data = flit_in.data[DATA_SIZE-1:0];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

    // en_q holds ready low for the whole reset and until the first edge after release.
    assign flit_in.r_ready = en_q & ((state_q == S_DROP) | ~full);
    assign accept          = flit_in.wr_ready & flit_in.r_ready;

    assign fifo_out.wr_ready = ~empty;
    assign fifo_out.data     = empty ? '0 : mem[rd_ptr_q[PW-2:0]];
    assign pop               = ~empty & fifo_out.r_ready;

    assign cnt_next = {1'b0, flit_cnt_q} + (CNT_W + 1)'(1);

    always_comb begin
        state_d    = state_q;
        flit_cnt_d = flit_cnt_q;
        push       = 1'b0;
        push_last  = flit_last;
        recv_inc   = 1'b0;
        addr_inc   = 1'b0;
        len_inc    = 1'b0;
        if (accept) begin
            unique case (state_q)
                S_IDLE: begin
                    if (flit_dst != MY_ADDR) begin
                        addr_inc = 1'b1;
                        if (!flit_last) state_d = S_DROP;
                    end else begin
                        push = 1'b1;
                        if (flit_last) begin
                            recv_inc = 1'b1;
                        end else if (MAX_PACK_LEN == 1) begin
                            push_last = 1'b1;
                            len_inc   = 1'b1;
                            state_d   = S_DROP;
                        end else begin
                            flit_cnt_d = CNT_W'(1);
                            state_d    = S_BODY;
                        end
                    end
                end
                S_BODY: begin
                    push       = 1'b1;
                    flit_cnt_d = cnt_next[CNT_W-1:0];
                    if (flit_last) begin
                        recv_inc = 1'b1;
                        state_d  = S_IDLE;
                    end else if (cnt_next == MAX_LEN_C) begin
                        // Truncate: close the packet in the FIFO and discard the rest.
                        push_last = 1'b1;
                        len_inc   = 1'b1;
                        state_d   = S_DROP;
                    end
                end
                S_DROP: begin
                    if (flit_last) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        recv_d     = recv_inc ? recv_q + 32'd1 : recv_q;
        addr_err_d = (addr_inc && addr_err_q != 16'hFFFF) ? addr_err_q + 16'd1 : addr_err_q;
        len_err_d  = (len_inc && len_err_q != 16'hFFFF) ? len_err_q + 16'd1 : len_err_q;
        if (accept)               idle_d = '0;
        else if (idle_q == IDLE_MAX) idle_d = idle_q;
        else                      idle_d = idle_q + 32'd1;
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q    <= S_IDLE;
            flit_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            recv_q     <= '0;
            addr_err_q <= '0;
            len_err_q  <= '0;
            idle_q     <= '0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            flit_cnt_q <= flit_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            recv_q     <= recv_d;
            addr_err_q <= addr_err_d;
            len_err_q  <= len_err_d;
            idle_q     <= idle_d;
            en_q       <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[PW-2:0]] <= {push_last, flit_data};
    end

    assign recv_packs = recv_q;
    assign addr_errs  = addr_err_q;
    assign len_errs   = len_err_q;
    assign timeout    = (idle_q == IDLE_MAX);
endmodule
